ps2_rx_frame: RTL and testbench

- PS/2 device-to-host receiver that feeds the keyboard register block; keyboard_wb consumes its byte/strobe pair unchanged.
- Synchronises and de-glitches PS2_CLK/PS2_DAT, deserialises 11-bit frames, and checks start, odd parity and stop bits.
- Delivers each good scan-code byte with a one-cycle strobe.
- Bad or stalled frames are dropped with an error strobe, so a noisy or hot-plugged keyboard cannot inject garbage codes.

---
 rtl/ps2_rx_frame.sv | 165 ++++++++++++++++
 tb/tb_ps2_rx_frame.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/ps2_rx_frame.sv
// PS/2 device-to-host frame receiver: sync, de-glitch, deserialise, check start/odd parity/stop.
// Optional saturating error counter enabled by macro PS2_RX_ERRCNT_EN.
module ps2_rx_frame #(
   parameter int FILTER_LEN  = 8,
   parameter int TIMEOUT_CYC = 48000,
   parameter int TO_W        = 17
) (
   input  logic       wb_clk,
   input  logic       nRESET,
   input  logic       PS2_CLK,
   input  logic       PS2_DAT,
   output logic [7:0] data,
   output logic       valid,
   output logic       error,
   output logic       busy,
   output logic [7:0] err_cnt
);

   // state | meaning
   // IDLE  | waiting for a start bit (fall with data low)
   // SHIFT | collecting 8 data bits, parity and stop; timeout armed
   // CHECK | one cycle to validate the frame and strobe valid or error
   typedef enum logic [1:0] {IDLE, SHIFT, CHECK} state_t;

   localparam logic [7:0]      F_LAST  = 8'(FILTER_LEN - 1);
   localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);

   logic [1:0]      clk_sync, dat_sync;
   logic            clk_filt, dat_filt, clk_filt_d;
   logic [7:0]      clk_fcnt, dat_fcnt;
   logic            fall;

   state_t          state, state_next;
   logic [9:0]      shreg, shreg_next;
   logic [3:0]      bitcnt, bitcnt_next;
   logic [TO_W-1:0] to_cnt, to_next;
   logic [7:0]      data_next;
   logic            valid_next, error_next;

   always_ff @(posedge wb_clk or negedge nRESET) begin
      if (!nRESET) begin
         clk_sync <= 2'b11;
         dat_sync <= 2'b11;
      end else begin
         clk_sync <= {clk_sync[0], PS2_CLK};
         dat_sync <= {dat_sync[0], PS2_DAT};
      end
   end

   // A line level only propagates after holding for FILTER_LEN consecutive samples.
   always_ff @(posedge wb_clk or negedge nRESET) begin
      if (!nRESET) begin
         clk_filt <= 1'b1;
         clk_fcnt <= 8'd0;
      end else if (clk_sync[1] == clk_filt) begin
         clk_fcnt <= 8'd0;
      end else if (clk_fcnt == F_LAST) begin
         clk_filt <= clk_sync[1];
         clk_fcnt <= 8'd0;
      end else begin
         clk_fcnt <= clk_fcnt + 8'd1;
      end
   end

   always_ff @(posedge wb_clk or negedge nRESET) begin
      if (!nRESET) begin
         dat_filt <= 1'b1;
         dat_fcnt <= 8'd0;
      end else if (dat_sync[1] == dat_filt) begin
         dat_fcnt <= 8'd0;
      end else if (dat_fcnt == F_LAST) begin
         dat_filt <= dat_sync[1];
         dat_fcnt <= 8'd0;
      end else begin
         dat_fcnt <= dat_fcnt + 8'd1;
      end
   end

   always_ff @(posedge wb_clk or negedge nRESET) begin
      if (!nRESET) clk_filt_d <= 1'b1;
      else         clk_filt_d <= clk_filt;
   end

   assign fall = clk_filt_d & ~clk_filt;

   always_ff @(posedge wb_clk or negedge nRESET) begin
      if (!nRESET) begin
         state  <= IDLE;
         shreg  <= 10'd0;
         bitcnt <= 4'd0;
         to_cnt <= '0;
         data   <= 8'h00;
         valid  <= 1'b0;
         error  <= 1'b0;
         busy   <= 1'b0;
      end else begin
         state  <= state_next;
         shreg  <= shreg_next;
         bitcnt <= bitcnt_next;
         to_cnt <= to_next;
         data   <= data_next;
         valid  <= valid_next;
         error  <= error_next;
         busy   <= (state_next != IDLE);
      end
   end

   always_comb begin
      state_next  = state;
      shreg_next  = shreg;
      bitcnt_next = bitcnt;
      to_next     = to_cnt;
      data_next   = data;
      valid_next  = 1'b0;
      error_next  = 1'b0;
      case (state)
         IDLE: begin
            if (fall && !dat_filt) begin
               state_next  = SHIFT;
               bitcnt_next = 4'd0;
               to_next     = '0;
            end
         end
         SHIFT: begin
            if (fall) begin
               shreg_next  = {dat_filt, shreg[9:1]};
               bitcnt_next = bitcnt + 4'd1;
               to_next     = '0;
               if (bitcnt == 4'd9) state_next = CHECK;
            end else if (to_cnt == TO_LAST) begin
               error_next = 1'b1;
               to_next    = '0;
               state_next = IDLE;
            end else begin
               to_next = to_cnt + 1'b1;
            end
         end
         CHECK: begin
            // shreg = {stop, parity, d7..d0}; odd parity means XOR over d0..parity is 1.
            if (shreg[9] && (^shreg[8:0])) begin
               data_next  = shreg[7:0];
               valid_next = 1'b1;
            end else begin
               error_next = 1'b1;
            end
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

`ifdef PS2_RX_ERRCNT_EN
   logic [7:0] err_cnt_q;

   always_ff @(posedge wb_clk or negedge nRESET) begin
      if (!nRESET)                           err_cnt_q <= 8'h00;
      else if (error && err_cnt_q != 8'hFF)  err_cnt_q <= err_cnt_q + 8'd1;
   end

   assign err_cnt = err_cnt_q;
`else
   assign err_cnt = 8'h00;
`endif

endmodule

// File: tb/tb_ps2_rx_frame.sv
// Scoreboard bench for ps2_rx_frame: frames queue their expected strobe, a monitor pops on valid/error.
module tb_ps2_rx_frame;

   localparam int FILTER_LEN  = 8;
   localparam int TIMEOUT_CYC = 1000;
   localparam int HP          = 9;
`ifdef PS2_RX_ERRCNT_EN
   localparam int N_BAD = 300;
`else
   localparam int N_BAD = 4;
`endif

   logic       wb_clk = 1'b0;
   logic       nRESET;
   logic       PS2_CLK, PS2_DAT;
   logic [7:0] data, err_cnt;
   logic       valid, error, busy;

   typedef struct packed {
      logic       is_err;
      logic [7:0] data;
   } exp_t;

   exp_t       q[$];
   logic [7:0] last_data = 8'h00;
   int         err_model = 0;
   int         n_chk = 0;
   int         n_err = 0;

   ps2_rx_frame #(.FILTER_LEN(FILTER_LEN), .TIMEOUT_CYC(TIMEOUT_CYC), .TO_W(17)) dut (
      .wb_clk (wb_clk),
      .nRESET (nRESET),
      .PS2_CLK(PS2_CLK),
      .PS2_DAT(PS2_DAT),
      .data   (data),
      .valid  (valid),
      .error  (error),
      .busy   (busy),
      .err_cnt(err_cnt)
   );

   always #5 wb_clk = ~wb_clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] exp_errcnt();
`ifdef PS2_RX_ERRCNT_EN
      return (err_model > 255) ? 32'd255 : 32'(err_model);
`else
      return 32'd0;
`endif
   endfunction

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge wb_clk);
         #1;
      end
   endtask

   task automatic drive_bit(input logic v);
      PS2_DAT = v;
      tick(HP);
      PS2_CLK = 1'b0;
      tick(HP);
      PS2_CLK = 1'b1;
   endtask

   task automatic send_frame(input logic [7:0] b, input logic bad_par, input logic stop);
      logic [10:0] bits;
      exp_t        e;
      bits = {stop, (~^b) ^ bad_par, b, 1'b0};
      if (!bad_par && stop) begin
         last_data = b;
         e = '{is_err: 1'b0, data: b};
      end else begin
         err_model++;
         e = '{is_err: 1'b1, data: last_data};
      end
      q.push_back(e);
      for (int i = 0; i < 11; i++) begin
         if (i == 5) chk("busy_mid", 32'(busy), 32'd1);
         drive_bit(bits[i]);
      end
      tick(HP);
   endtask

   task automatic drain(input int bound);
      int n = 0;
      while (q.size() != 0 && n < bound) begin
         tick(1);
         n++;
      end
      chk("drain", 32'(q.size()), 32'd0);
      tick(5);
   endtask

   always @(negedge wb_clk) begin
      if (nRESET && (valid || error)) begin
         chk("strobe_excl", 32'(valid & error), 32'd0);
         if (q.size() == 0) begin
            chk("unexpected_strobe", {30'd0, valid, error}, 32'd0);
         end else begin
            exp_t e;
            e = q.pop_front();
            chk("strobe_kind", 32'(error), 32'(e.is_err));
            chk("data", 32'(data), 32'(e.data));
            chk("busy_at_strobe", 32'(busy), 32'd0);
         end
      end
   end

   initial begin
      logic seen;
      nRESET  = 1'b0;
      PS2_CLK = 1'b1;
      PS2_DAT = 1'b1;
      tick(3);
      chk("rst_data", 32'(data), 32'h00);
      chk("rst_valid", 32'(valid), 32'd0);
      chk("rst_error", 32'(error), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_errcnt", 32'(err_cnt), 32'd0);
      nRESET = 1'b1;
      tick(5);

      send_frame(8'h1C, 1'b0, 1'b1);
      drain(50);
      send_frame(8'h1C, 1'b1, 1'b1);
      drain(50);
      chk("errcnt_parity", 32'(err_cnt), exp_errcnt());
      send_frame(8'hF0, 1'b0, 1'b0);
      drain(50);
      send_frame(8'h12, 1'b0, 1'b1);
      drain(50);

      PS2_CLK = 1'b0;
      tick(5);
      PS2_CLK = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 25; i++) begin
         tick(1);
         seen = seen | busy;
      end
      chk("glitch_busy", 32'(seen), 32'd0);
      send_frame(8'hE0, 1'b0, 1'b1);
      drain(50);

      q.push_back('{is_err: 1'b1, data: last_data});
      err_model++;
      drive_bit(1'b0);
      drive_bit(1'b0);
      drive_bit(1'b0);
      drive_bit(1'b1);
      drive_bit(1'b1);
      drain(TIMEOUT_CYC + 200);
      chk("timeout_busy", 32'(busy), 32'd0);
      chk("errcnt_timeout", 32'(err_cnt), exp_errcnt());
      send_frame(8'h58, 1'b0, 1'b1);
      drain(50);

      drive_bit(1'b0);
      for (int i = 0; i < 5; i++) drive_bit(1'b1);
      tick(3);
      nRESET = 1'b0;
      #1;
      last_data = 8'h00;
      err_model = 0;
      chk("midrst_data", 32'(data), 32'h00);
      chk("midrst_valid", 32'(valid), 32'd0);
      chk("midrst_error", 32'(error), 32'd0);
      chk("midrst_busy", 32'(busy), 32'd0);
      chk("midrst_errcnt", 32'(err_cnt), 32'd0);
      tick(3);
      nRESET = 1'b1;
      tick(2);
      for (int i = 0; i < 5; i++) drive_bit(1'b1);
      tick(30);
      chk("post_rst_busy", 32'(busy), 32'd0);
      drain(10);

      for (int i = 0; i < N_BAD; i++) begin
         logic [7:0] b;
         b = 8'($urandom);
         if (i % 2 == 1) send_frame(b, 1'b1, 1'b1);
         else            send_frame(b, 1'b0, 1'b0);
         drain(50);
      end
      chk("errcnt_sat", 32'(err_cnt), exp_errcnt());

      send_frame(8'hA5, 1'b0, 1'b1);
      drain(50);
      chk("final_data", 32'(data), 32'hA5);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
